// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
// Four-requester round-robin arbiter with a bounded hold time.
// A granted requester keeps the resource while it requests, but once it has
// held it for MAX_HOLD cycles and someone else is waiting, it is preempted.
// All outputs are registered; there is no combinational req->gnt path.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   req        in   4  request lines, req[i]=1 -> requester i wants the resource
//   gnt        out  4  one-hot grant or all-zero
//   gnt_idx    out  2  binary index of gnt (00 when no grant)
//   gnt_valid  out  1  any grant bit set
//   gnt_new    out  1  single-cycle pulse in the first cycle of each new grant
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_new
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      idx_q, idx_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      gnt_idx_q, gnt_idx_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            gnt_new_q, gnt_new_d;

    logic [1:0]      winner_s;
    logic            new_grant_s;

    // One-hot decode of a 2-bit index.
    function automatic logic [3:0] onehot(input logic [1:0] i);
        logic [3:0] v;
        case (i)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    // First set request scanning upward from p, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] c;
        logic       found;
        w     = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = p + i[1:0];
            if (!found && r[c]) begin
                w     = c;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Winner of a fresh arbitration round. While granting, ptr_q = idx_q+1,
    // so the current holder is automatically the lowest priority.
    always_comb begin
        winner_s = pick(req, ptr_q);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        hold_cnt_d  = hold_cnt_q;
        new_grant_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    new_grant_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (req[idx_q]) begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end else if ((req & ~onehot(idx_q)) != 4'b0000) begin
                        new_grant_s = 1'b1;
                    end else begin
                        hold_cnt_d = HOLD_LAST;
                    end
                end else if (req != 4'b0000) begin
                    new_grant_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_grant_s) begin
            state_d    = ST_GRANT;
            idx_d      = winner_s;
            hold_cnt_d = '0;
            ptr_d      = winner_s + 2'd1;
        end else begin
            idx_d = idx_d;
        end

        if (state_d == ST_GRANT) begin
            gnt_d       = onehot(idx_d);
            gnt_idx_d   = idx_d;
            gnt_valid_d = 1'b1;
        end else begin
            gnt_d       = 4'b0000;
            gnt_idx_d   = 2'b00;
            gnt_valid_d = 1'b0;
        end
        gnt_new_d = new_grant_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'b00;
            gnt_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_new_q   <= gnt_new_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_new   = gnt_new_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4
// Directed bench for rr_arbiter_4 (MAX_HOLD=4). Each step drives req just after
// a rising edge, waits one edge and checks {gnt, gnt_idx, gnt_valid, gnt_new}
// against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_new;

    int n_checks;
    int n_fail;

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_new   (gnt_new)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected word layout: {gnt[3:0], gnt_idx[1:0], gnt_valid, gnt_new}
    function automatic logic [7:0] exp_gnt(input logic [1:0] w, input logic nw);
        logic [3:0] oh;
        oh = 4'b0001 << w;
        return {oh, w, 1'b1, nw};
    endfunction

    task automatic check(input string tag, input logic [7:0] e);
        logic [7:0] o;
        o = {gnt, gnt_idx, gnt_valid, gnt_new};
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed gnt/idx/valid/new=%b expected %b", tag, o, e);
        end
    endtask

    // Drive req, advance one rising edge, sample 1 ns later and compare.
    task automatic step(input logic [3:0] r, input string tag, input logic [7:0] e);
        req = r;
        @(posedge clk);
        #1;
        check(tag, e);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        #12;
        check("reset_state", 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        step(4'b0000, "idle_no_req", 8'h00);

        // First grant, one edge latency, single gnt_new pulse.
        step(4'b0001, "first_grant", exp_gnt(2'd0, 1'b1));
        step(4'b0001, "first_grant_hold", exp_gnt(2'd0, 1'b0));
        step(4'b0000, "release_idle", 8'h00);

        // Fresh reset, then all requesting: 0,1,2,3,0 for 4 cycles each.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                step(4'b1111, $sformatf("rr_all_g%0d_c%0d", g, c),
                     exp_gnt(g[1:0], (c == 0) ? 1'b1 : 1'b0));
            end
        end

        // Lone requester keeps the grant well past MAX_HOLD.
        step(4'b0100, "lone_first", exp_gnt(2'd2, 1'b1));
        for (int c = 1; c < 20; c++) begin
            step(4'b0100, $sformatf("lone_c%0d", c), exp_gnt(2'd2, 1'b0));
        end

        // Holder drops, direct handoff; ptr=3 so 1 wins, then ptr=2 so 3 wins.
        step(4'b0010, "handoff_to_1", exp_gnt(2'd1, 1'b1));
        step(4'b1001, "handoff_to_3", exp_gnt(2'd3, 1'b1));
        step(4'b1011, "others_no_disturb", exp_gnt(2'd3, 1'b0));

        // Asynchronous reset mid-cycle clears outputs before any edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00);
        #1;
        rst = 1'b0;
        step(4'b0110, "after_reset_ptr0", exp_gnt(2'd1, 1'b1));

        // Grant to 2 (ptr=3), go idle, then scan from 3 finds 0.
        step(4'b0100, "grant_to_2", exp_gnt(2'd2, 1'b1));
        step(4'b0000, "drop_to_idle", 8'h00);
        step(4'b0001, "ptr3_scan", exp_gnt(2'd0, 1'b1));
        // ptr=1 kept across idle: 1001 -> 3 wins, not 0.
        step(4'b0000, "idle_again", 8'h00);
        step(4'b1001, "ptr1_kept", exp_gnt(2'd3, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before preemption when another requester waits; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; req[i]=1 means requester i wants the shared resource.
REQ-005 gnt  output 4  grant, one-hot or all-zero, registered.
REQ-006 gnt_idx  output 2  binary index of the granted requester, registered; 0001->00, 0010->01, 0100->10, 1000->11; 00 when gnt=0000.
REQ-007 gnt_valid  output 1  1 when any gnt bit set, registered.
REQ-008 gnt_new  output 1  one-cycle pulse in the first cycle of every new grant, registered.

Function
REQ-009 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-010 Internal state SHALL comprise: 2-bit priority pointer ptr, current index, hold counter hold_cnt sized to hold MAX_HOLD-1.
REQ-011 Winner selection SHALL scan req starting at index ptr, ascending modulo 4, choosing the first set bit.
REQ-012 IDLE, req=0000: remain IDLE, all outputs zero.
REQ-013 IDLE, req!=0000 at a clock edge: at that edge enter GRANT with the winner; latency req->gnt is exactly one edge.
REQ-014 On every new grant to index w: gnt=one-hot(w), gnt_idx=w, gnt_valid=1, gnt_new=1 for one cycle, hold_cnt=0, ptr=(w+1) mod 4 (2-bit wrap, 3->0).
REQ-015 GRANT, req[idx]=1, hold_cnt<MAX_HOLD-1: keep grant, hold_cnt increments, gnt_new=0.
REQ-016 GRANT, req[idx]=1, hold_cnt=MAX_HOLD-1, no other req set: keep grant, hold_cnt saturates at MAX_HOLD-1, no preemption.
REQ-017 GRANT, req[idx]=1, hold_cnt=MAX_HOLD-1, another req set: preempt; at that edge grant the winner per REQ-011 (current holder lowest priority since ptr=idx+1).
REQ-018 GRANT, req[idx]=0, other req set: at that edge grant the winner directly, no idle cycle between grants.
REQ-019 GRANT, req=0000: at that edge return to IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, gnt_new=0; ptr unchanged.
REQ-020 Requests arriving or dropping on non-holder lines during GRANT SHALL NOT disturb the current grant.
REQ-021 gnt SHALL never have more than one bit set; gnt_idx SHALL always equal the encoded gnt.
REQ-022 Outputs SHALL depend only on registers (no combinational req->gnt path).

Reset
REQ-023 rst=1 SHALL immediately, without clock, force: state IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, gnt_new=0, ptr=0, hold_cnt=0.
REQ-024 Reset asserted mid-grant SHALL abandon the grant; the first edge after rst deasserts SHALL arbitrate from ptr=0.

Verification
REQ-025 Reset, then req=0001 -> after 1 edge gnt=0001, gnt_idx=00, gnt_valid=1, gnt_new=1 for one cycle.
REQ-026 MAX_HOLD=4, req=1111 held -> grants 0,1,2,3,0 each lasting exactly 4 cycles, gnt_new pulse at each change.
REQ-027 req=0100 alone for 20 cycles -> gnt=0100 continuous, gnt_new only in first cycle, no drop.
REQ-028 gnt=0010 active, req changes to 1001 -> next edge gnt=1000, gnt_idx=11, no zero cycle.
REQ-029 gnt=1000 active, rst pulsed mid-cycle -> outputs zero before next edge; after release with req=0110 -> gnt=0010.
REQ-030 gnt active, req -> 0000 -> next edge gnt=0000, gnt_valid=0; then req=0001 after prior grant to 2 -> ptr=3 scan, gnt=0001.
